// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: entry layout, register address type and default sizing.
// Used by reorder_buffer and rob_retire_sel.
package reorder_buffer_pkg;

   localparam int unsigned ROB_DEPTH = 32;
   localparam int unsigned ROB_IDX_W = $clog2(ROB_DEPTH);

   typedef logic [5:0]           reg_addr_t;
   typedef logic [ROB_IDX_W-1:0] rob_idx_t;

   typedef struct packed {
      logic        valid;
      logic        complete;
      logic        exc;
      logic        rf_we;
      reg_addr_t   dest;
      reg_addr_t   phy_dest;
      reg_addr_t   old_dest;
      logic [31:0] pc;
   } rob_entry_t;

   // Freshly allocated entry: valid, not yet complete, no exception.
   function automatic rob_entry_t rob_new_entry(input logic        rf_we,
                                                input reg_addr_t   dest,
                                                input reg_addr_t   phy_dest,
                                                input reg_addr_t   old_dest,
                                                input logic [31:0] pc);
      rob_entry_t e;
      e.valid    = 1'b1;
      e.complete = 1'b0;
      e.exc      = 1'b0;
      e.rf_we    = rf_we;
      e.dest     = dest;
      e.phy_dest = phy_dest;
      e.old_dest = old_dest;
      e.pc       = pc;
      return e;
   endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// Retire/flush selection from the two oldest ROB entries. Purely combinational.
module rob_retire_sel
   import reorder_buffer_pkg::*;
(
   input  rob_entry_t  head0_i,
   input  rob_entry_t  head1_i,
   output logic        slot1_retire_o,
   output logic        slot2_retire_o,
   output logic        flush_o,
   output logic [31:0] flush_pc_o
);

   logic done0, done1;

   always_comb begin
      done0          = head0_i.valid & head0_i.complete;
      done1          = head1_i.valid & head1_i.complete;
      slot1_retire_o = done0 & ~head0_i.exc;
      slot2_retire_o = slot1_retire_o & done1 & ~head1_i.exc;
      flush_o        = 1'b0;
      flush_pc_o     = '0;
      if (done0 && head0_i.exc) begin
         flush_o    = 1'b1;
         flush_pc_o = head0_i.pc;
      end else if (slot1_retire_o && done1 && head1_i.exc) begin
         // Slot1 still commits; the younger excepting entry triggers the flush.
         flush_o    = 1'b1;
         flush_pc_o = head1_i.pc;
      end
   end

   logic unused_fields;
   assign unused_fields = ^{head0_i.rf_we, head0_i.dest, head0_i.phy_dest, head0_i.old_dest,
                            head1_i.rf_we, head1_i.dest, head1_i.phy_dest, head1_i.old_dest};

endmodule

// File: rtl/reorder_buffer.sv
// Dual-issue in-order reorder buffer: 2-wide allocate, 2 writeback ports, 2-wide retire + flush.
// Define ROB_PERF_CNT_EN to add the perf_retired/perf_full_stall/perf_flush counters.
module reorder_buffer #(
   parameter int unsigned ROB_DEPTH = reorder_buffer_pkg::ROB_DEPTH,
   parameter int unsigned ROB_IDX_W = reorder_buffer_pkg::ROB_IDX_W
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 alloc_inst1_valid_i,
   input  logic                 alloc_inst1_rf_we_i,
   input  logic [5:0]           alloc_inst1_dest_i,
   input  logic [5:0]           alloc_inst1_phy_dest_i,
   input  logic [5:0]           alloc_inst1_old_dest_i,
   input  logic [31:0]          alloc_inst1_pc_i,
   input  logic                 alloc_inst2_valid_i,
   input  logic                 alloc_inst2_rf_we_i,
   input  logic [5:0]           alloc_inst2_dest_i,
   input  logic [5:0]           alloc_inst2_phy_dest_i,
   input  logic [5:0]           alloc_inst2_old_dest_i,
   input  logic [31:0]          alloc_inst2_pc_i,
   output logic                 rob_ready_o,
   output logic [ROB_IDX_W-1:0] alloc_inst1_idx_o,
   output logic [ROB_IDX_W-1:0] alloc_inst2_idx_o,
   input  logic                 wb1_valid_i,
   input  logic [ROB_IDX_W-1:0] wb1_idx_i,
   input  logic                 wb1_exc_i,
   input  logic                 wb2_valid_i,
   input  logic [ROB_IDX_W-1:0] wb2_idx_i,
   input  logic                 wb2_exc_i,
   output logic                 retire_inst1_rf_we_o,
   output logic [5:0]           retire_inst1_dest_o,
   output logic [5:0]           retire_inst1_old_dest_o,
   output logic [5:0]           retire_inst1_phy_dest_o,
   output logic                 retire_inst2_rf_we_o,
   output logic [5:0]           retire_inst2_dest_o,
   output logic [5:0]           retire_inst2_old_dest_o,
   output logic [5:0]           retire_inst2_phy_dest_o,
   output logic [1:0]           retire_count_o,
   output logic                 flush_o,
   output logic [31:0]          flush_pc_o,
   output logic                 rob_empty_o
`ifdef ROB_PERF_CNT_EN
   ,
   output logic [31:0]          perf_retired_o,
   output logic [31:0]          perf_full_stall_o,
   output logic [31:0]          perf_flush_o
`endif
);

   import reorder_buffer_pkg::*;

   localparam int unsigned PtrW = ROB_IDX_W + 1;
   typedef logic [PtrW-1:0]      ptr_t;
   typedef logic [ROB_IDX_W-1:0] idx_t;

   rob_entry_t entries_q [ROB_DEPTH];
   rob_entry_t entries_d [ROB_DEPTH];
   ptr_t       head_q, head_d, tail_q, tail_d;
   ptr_t       count;
   idx_t       head_idx, head1_idx, tail_idx;
   logic       alloc_fire, slot1_retire, slot2_retire;
   rob_entry_t head0_entry, head1_entry;

   assign count       = tail_q - head_q;
   assign rob_ready_o = count <= ptr_t'(ROB_DEPTH - 2);
   assign rob_empty_o = count == '0;

   assign head_idx    = head_q[ROB_IDX_W-1:0];
   assign head1_idx   = head_idx + idx_t'(1);
   assign tail_idx    = tail_q[ROB_IDX_W-1:0];
   assign head0_entry = entries_q[head_idx];
   assign head1_entry = entries_q[head1_idx];

   assign alloc_inst1_idx_o = tail_idx;
   assign alloc_inst2_idx_o = alloc_inst1_valid_i ? tail_idx + idx_t'(1) : tail_idx;
   assign alloc_fire = rob_ready_o & (alloc_inst1_valid_i | alloc_inst2_valid_i) & ~flush_o;

   rob_retire_sel u_retire_sel (
      .head0_i        (head0_entry),
      .head1_i        (head1_entry),
      .slot1_retire_o (slot1_retire),
      .slot2_retire_o (slot2_retire),
      .flush_o        (flush_o),
      .flush_pc_o     (flush_pc_o)
   );

   assign retire_count_o          = {slot2_retire, slot1_retire & ~slot2_retire};
   assign retire_inst1_rf_we_o    = slot1_retire & head0_entry.rf_we;
   assign retire_inst1_dest_o     = head0_entry.dest;
   assign retire_inst1_old_dest_o = head0_entry.old_dest;
   assign retire_inst1_phy_dest_o = head0_entry.phy_dest;
   assign retire_inst2_rf_we_o    = slot2_retire & head1_entry.rf_we;
   assign retire_inst2_dest_o     = head1_entry.dest;
   assign retire_inst2_old_dest_o = head1_entry.old_dest;
   assign retire_inst2_phy_dest_o = head1_entry.phy_dest;

   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      if (flush_o) begin
         // Payload fields are left stale; only the status bits matter once valid is clear.
         for (int i = 0; i < ROB_DEPTH; i++) begin
            entries_d[i].valid    = 1'b0;
            entries_d[i].complete = 1'b0;
            entries_d[i].exc      = 1'b0;
         end
         head_d = '0;
         tail_d = '0;
      end else begin
         if (wb1_valid_i && entries_q[wb1_idx_i].valid) begin
            entries_d[wb1_idx_i].complete = 1'b1;
            entries_d[wb1_idx_i].exc      = entries_d[wb1_idx_i].exc | wb1_exc_i;
         end
         if (wb2_valid_i && entries_q[wb2_idx_i].valid) begin
            entries_d[wb2_idx_i].complete = 1'b1;
            entries_d[wb2_idx_i].exc      = entries_d[wb2_idx_i].exc | wb2_exc_i;
         end
         if (slot1_retire) begin
            entries_d[head_idx].valid    = 1'b0;
            entries_d[head_idx].complete = 1'b0;
         end
         if (slot2_retire) begin
            entries_d[head1_idx].valid    = 1'b0;
            entries_d[head1_idx].complete = 1'b0;
         end
         head_d = head_q + ptr_t'(retire_count_o);
         if (alloc_fire) begin
            if (alloc_inst1_valid_i) begin
               entries_d[alloc_inst1_idx_o] = rob_new_entry(alloc_inst1_rf_we_i,
                  alloc_inst1_dest_i, alloc_inst1_phy_dest_i, alloc_inst1_old_dest_i,
                  alloc_inst1_pc_i);
            end
            if (alloc_inst2_valid_i) begin
               entries_d[alloc_inst2_idx_o] = rob_new_entry(alloc_inst2_rf_we_i,
                  alloc_inst2_dest_i, alloc_inst2_phy_dest_i, alloc_inst2_old_dest_i,
                  alloc_inst2_pc_i);
            end
            tail_d = tail_q + ptr_t'(alloc_inst1_valid_i) + ptr_t'(alloc_inst2_valid_i);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q <= '0;
         tail_q <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         entries_q <= entries_d;
      end
   end

`ifdef ROB_PERF_CNT_EN
   logic [31:0] perf_retired_q, perf_full_stall_q, perf_flush_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_retired_q    <= '0;
         perf_full_stall_q <= '0;
         perf_flush_q      <= '0;
      end else begin
         perf_retired_q    <= perf_retired_q + 32'(retire_count_o);
         perf_full_stall_q <= perf_full_stall_q +
                              32'((alloc_inst1_valid_i | alloc_inst2_valid_i) & ~rob_ready_o);
         perf_flush_q      <= perf_flush_q + 32'(flush_o);
      end
   end

   assign perf_retired_o    = perf_retired_q;
   assign perf_full_stall_o = perf_full_stall_q;
   assign perf_flush_o      = perf_flush_q;
`endif

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
In-order retirement buffer that sits directly downstream of RAT rename. It accepts up to two renamed instructions per cycle and records their writeback completion. Up to two instructions retire per cycle in program order, driving the RAT commit interface (retire_inst*_rf_we/dest/old_dest/phy_dest). On an excepting head instruction it raises a one-cycle flush that restores the RAT and free list to commit state.

Parameters:
ROB_DEPTH, 32, number of entries; power of two, at least 4
ROB_IDX_W, 5, log2(ROB_DEPTH)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
alloc_inst1_valid  in  1  inst1 renamed and presented
alloc_inst1_rf_we / alloc_inst1_dest / alloc_inst1_phy_dest / alloc_inst1_old_dest  in  1/6/6/6  rename results for inst1
alloc_inst1_pc  in  32  PC of inst1
alloc_inst2_valid, alloc_inst2_rf_we / _dest / _phy_dest / _old_dest / _pc  in  1/1/6/6/6/32  same fields for inst2 (younger)
rob_ready  out  1  at least two free entries
alloc_inst1_idx, alloc_inst2_idx  out  ROB_IDX_W  entries assigned to inst1/inst2
wb1_valid, wb2_valid  in  1  writeback completion strobes
wb1_idx, wb2_idx  in  ROB_IDX_W  ROB entry completed
wb1_exc, wb2_exc  in  1  completing instruction raised an exception
retire_inst1_rf_we, retire_inst2_rf_we  out  1  retire strobe gated by rf_we
retire_inst1_dest / _old_dest / _phy_dest, retire_inst2_dest / _old_dest / _phy_dest  out  6  commit mapping info
retire_count  out  2  instructions retired this cycle (0..2)
flush  out  1  one-cycle pipeline flush
flush_pc  out  32  PC of excepting instruction
rob_empty  out  1  no valid entries

Behaviour:
- Pointers head/tail are ROB_IDX_W+1 bits with a wrap bit. count = tail-head. Full when count==ROB_DEPTH. rob_ready = (ROB_DEPTH-count) >= 2, registered-free (combinational from pointers).
- Allocation fires when rob_ready && (inst1_valid || inst2_valid). If only inst2_valid, inst2 takes tail. alloc_inst1_idx=tail and alloc_inst2_idx=tail+1 when both are valid. tail advances by the number of valid instructions. A new entry is written with complete=0 and exc=0.
- Writeback: wbN_valid sets complete[idx]=1 and exc[idx]|=wbN_exc in the next cycle. If both ports target the same idx, OR them. A writeback to a non-valid entry is ignored.
- Retire is combinational from the registered state:
  - slot1 retires when the head entry is valid, complete and exc=0.
  - slot2 retires when slot1 retires and head+1 is valid, complete and exc=0.
  - head advances by retire_count at the clock edge.
  - retire_instN_rf_we = retires && entry.rf_we. Dest fields are always driven from the entries; they are don't-care unless the strobe is set.
- Exception: when the head entry is valid, complete and exc=1, assert flush=1 and flush_pc=entry.pc that cycle, with no retire from that slot. If slot1 retires normally and head+1 is an exception, slot1 retires and flush asserts the same cycle for head+1. The next cycle has head=tail=0, all valid bits clear and rob_empty=1. Allocation and writeback in the flush cycle are discarded.
- Simultaneous allocation and retire in the same cycle are legal. rob_ready uses pre-retire count, which is conservative.
- Reset (async, any time): head=tail=0, all valid/complete/exc=0. Outputs after reset: rob_ready=1, rob_empty=1, flush=0, retire strobes=0, retire_count=0, flush_pc=0, idx outputs=0.

Optional Feature:
ROB_PERF_CNT_EN
- Defined: adds 32-bit outputs perf_retired (cumulative retire_count), perf_full_stall (cycles with alloc valid and !rob_ready) and perf_flush (flush count). All reset to 0 and wrap at 2^32.
- Undefined: these ports and their logic are absent. Retire, flush and allocation behaviour is identical either way.

Decomposition:
- Shared cpu package: rob_idx_t, rob_entry_t (valid, complete, exc, rf_we, dest, phy_dest, old_dest, pc) and ROB_DEPTH. Reuse the existing reg_addr_t.
- One sub-module, rob_retire_sel: combinational slot1/slot2 retire and flush selection from the two head entries.

Test Plan:
- Reset; allocate inst1 (rf_we=1, dest=5, phy=33, old=5) and inst2 (dest=6, phy=34) -> idx 0/1; writeback both -> next cycle retire_count=2 with strobes and fields matching, rob_empty=1.
- Complete idx1 before idx0 -> no retire until idx0 completes, then both retire in the same cycle.
- Fill 30 entries -> rob_ready=1; fill 31 -> rob_ready=0; retire 2 -> rob_ready=1; continue allocating across index 31->0 -> wrap is correct.
- idx0 completes normally; idx1 has wb_exc=1 with pc=0xBFC00380 -> slot1 retires, flush=1, flush_pc=0xBFC00380; next cycle rob_empty=1 and the idx2 alloc in the flush cycle is dropped.
- Same-idx dual writeback with wb2_exc=1 -> entry flagged as exception and flushes at head.
- Assert reset low mid-stream with 10 entries valid -> outputs immediately at reset values; after release, allocation restarts at idx 0.
